pseudo_spi_in_intf: RTL and testbench

- Receive-side counterpart of the pseudo-SPI output interface.
- Generates the two-phase scan clocks (SCLK1/SCLK2) and a select pulse toward the analog device, and shifts serial data in LSB-first.
- Assembles each group of MEMORY_DATA_WIDTH bits into one word and writes it to SRAM, starting at ADDR_BGN, for DATA_LEN words.
- Sits between the CPU I/O controller (which drives BGN and owns the SRAM mux) and the analog scan chain.

---
 rtl/pseudo_spi_in_intf_pkg.sv | 26 ++
 rtl/pseudo_spi_in_intf_clk_phase_gen.sv | 34 +++
 rtl/pseudo_spi_in_intf.sv | 131 +++++++++++++
 tb/tb_pseudo_spi_in_intf.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pseudo_spi_in_intf_pkg.sv
// Shared encodings and timing constants for the pseudo-SPI receive interface.
// Shared with the output interface: the phase generator takes its constants from here.
package pseudo_spi_in_intf_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSel   = 3'd1,
    StRecv  = 3'd2,
    StWrite = 3'd3,
    StNext  = 3'd4,
    StDone  = 3'd5
  } pspi_state_e;

  localparam int unsigned PSPI_BIT_PHASES  = 5;
  localparam int unsigned PSPI_SEL_CYCLES  = 2;
  localparam int unsigned PSPI_PHASE_W     = $clog2(PSPI_BIT_PHASES);
  localparam int unsigned PSPI_SEL_CNT_W   = $clog2(PSPI_SEL_CYCLES);
  localparam int unsigned PSPI_SCLK1_PHASE = 1;
  localparam int unsigned PSPI_SCLK2_PHASE = 3;

  // States in which this block owns the SRAM/IO mux.
  function automatic logic pspi_mux_owned(input pspi_state_e st);
    return (st == StSel) || (st == StRecv) || (st == StWrite) || (st == StNext);
  endfunction

endpackage

// File: rtl/pseudo_spi_in_intf_clk_phase_gen.sv
// pspi_clk_phase_gen: per-bit phase counter and two-phase scan clock decode.
// Counts 0..PSPI_BIT_PHASES-1 while enabled and rests at 0 otherwise.
module pspi_clk_phase_gen
  import pseudo_spi_in_intf_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic last_o,
  output logic sclk1_o,
  output logic sclk2_o
);

  logic [PSPI_PHASE_W-1:0] phase_q, phase_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    last_o  = en_i && (phase_q == PSPI_PHASE_W'(PSPI_BIT_PHASES - 1));
    sclk1_o = en_i && (phase_q == PSPI_PHASE_W'(PSPI_SCLK1_PHASE));
    sclk2_o = en_i && (phase_q == PSPI_PHASE_W'(PSPI_SCLK2_PHASE));
    phase_d = '0;
    if (en_i && !last_o) begin
      phase_d = phase_q + PSPI_PHASE_W'(1);
    end
  end

endmodule

// File: rtl/pseudo_spi_in_intf.sv
// Pseudo-SPI receive interface: scans words in from the analog chain and writes them to SRAM.
// Build option PSEUDO_SPI_IN_MSB_FIRST_EN shifts MSB-first instead of the default LSB-first.
module pseudo_spi_in_intf
  import pseudo_spi_in_intf_pkg::*;
#(
  parameter int unsigned MEMORY_DATA_WIDTH = 8,
  parameter int unsigned MEMORY_ADDR_WIDTH = 9,
  parameter int unsigned RESERVED_DATA_LEN = 8
) (
  input  logic                         CLK,
  input  logic                         BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic                         SPI_SI,
  output logic                         SCLK1,
  output logic                         SCLK2,
  output logic                         SEL,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] PO,
  output logic                         CEN,
  output logic                         D_WE,
  output logic                         spi_MUX,
  output logic                         spi_is_done
);

  localparam int unsigned BitCntW = (MEMORY_DATA_WIDTH > 1) ? $clog2(MEMORY_DATA_WIDTH) : 1;

  pspi_state_e                  state_q, state_d;
  logic [PSPI_SEL_CNT_W-1:0]    sel_cnt_q, sel_cnt_d;
  logic [BitCntW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [MEMORY_DATA_WIDTH-1:0] shreg_q, shreg_d, shreg_in;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RESERVED_DATA_LEN-1:0] len_q, len_d;
  logic                         phase_last;

  pspi_clk_phase_gen u_clk_phase_gen (
    .clk_i   (CLK),
    .rst_ni  (BGN),
    .en_i    (state_q == StRecv),
    .last_o  (phase_last),
    .sclk1_o (SCLK1),
    .sclk2_o (SCLK2)
  );

  // Address and length are parameters of the next transfer: they track the inputs while BGN is low.
  always_ff @(posedge CLK or negedge BGN) begin
    if (!BGN) begin
      state_q   <= StIdle;
      sel_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      addr_q    <= ADDR_BGN;
      len_q     <= DATA_LEN;
    end else begin
      state_q   <= state_d;
      sel_cnt_q <= sel_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
    end
  end

`ifdef PSEUDO_SPI_IN_MSB_FIRST_EN
  assign shreg_in = {shreg_q[MEMORY_DATA_WIDTH-2:0], SPI_SI};
`else
  assign shreg_in = {SPI_SI, shreg_q[MEMORY_DATA_WIDTH-1:1]};
`endif

  always_comb begin
    state_d   = state_q;
    sel_cnt_d = sel_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    addr_d    = addr_q;
    len_d     = len_q;
    case (state_q)
      StIdle: begin
        sel_cnt_d = '0;
        state_d   = StSel;
      end
      StSel: begin
        if (sel_cnt_q == PSPI_SEL_CNT_W'(PSPI_SEL_CYCLES - 1)) begin
          sel_cnt_d = '0;
          state_d   = (len_q != '0) ? StRecv : StDone;
        end else begin
          sel_cnt_d = sel_cnt_q + PSPI_SEL_CNT_W'(1);
        end
      end
      StRecv: begin
        // Data is taken only on the edge closing the last phase of the bit slot.
        if (phase_last) begin
          shreg_d = shreg_in;
          if (bit_cnt_q == BitCntW'(MEMORY_DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = StWrite;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      StWrite: begin
        state_d = StNext;
      end
      StNext: begin
        addr_d = addr_q + MEMORY_ADDR_WIDTH'(1);
        if (len_q != '0) begin
          len_d = len_q - RESERVED_DATA_LEN'(1);
        end
        state_d = (len_q > RESERVED_DATA_LEN'(1)) ? StRecv : StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StDone;
      end
    endcase
  end

  always_comb begin
    SEL         = (state_q == StSel);
    CEN         = (state_q != StWrite);
    D_WE        = (state_q != StWrite);
    A           = addr_q;
    PO          = shreg_q;
    spi_MUX     = pspi_mux_owned(state_q);
    spi_is_done = (state_q == StDone);
  end

endmodule

// File: tb/tb_pseudo_spi_in_intf.sv
// Self-checking bench for pseudo_spi_in_intf: random serial data and noise against a timeline model.
module tb_pseudo_spi_in_intf;

  localparam int W       = 8;
  localparam int AW      = 9;
  localparam int SLOT    = 5;
  localparam int WORD_CY = SLOT * W + 2;

  logic          CLK;
  logic          BGN;
  logic [AW-1:0] ADDR_BGN;
  logic [7:0]    DATA_LEN;
  logic          SPI_SI;
  logic          SCLK1, SCLK2, SEL, CEN, D_WE, spi_MUX, spi_is_done;
  logic [AW-1:0] A;
  logic [W-1:0]  PO;

  int vectors;
  int miscompares;
  logic [W-1:0] words [256];

  pseudo_spi_in_intf dut (
    .CLK         (CLK),
    .BGN         (BGN),
    .ADDR_BGN    (ADDR_BGN),
    .DATA_LEN    (DATA_LEN),
    .SPI_SI      (SPI_SI),
    .SCLK1       (SCLK1),
    .SCLK2       (SCLK2),
    .SEL         (SEL),
    .A           (A),
    .PO          (PO),
    .CEN         (CEN),
    .D_WE        (D_WE),
    .spi_MUX     (spi_MUX),
    .spi_is_done (spi_is_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Word as stored in SRAM given the bit sequence sent (sent[i] is the i-th bit on the wire).
  function automatic logic [W-1:0] exp_word(input logic [W-1:0] sent);
    logic [W-1:0] w;
`ifdef PSEUDO_SPI_IN_MSB_FIRST_EN
    for (int i = 0; i < W; i++) w[W-1-i] = sent[i];
`else
    w = sent;
`endif
    return w;
  endfunction

  // Expected outputs in the cycle following posedge c (c = 0 is the cycle in which BGN rose).
  // vec = {SCLK1, SCLK2, SEL, CEN, D_WE, spi_MUX, spi_is_done}; r = cycle within word, -1 if none.
  function automatic void model_cycle(input int c, input logic [AW-1:0] addr, input int len,
                                      output logic [6:0] vec, output logic [AW-1:0] a,
                                      output int k, output int r);
    int t;
    int ph;
    t = c - 3;
    k = 0;
    r = -1;
    if (c < 1) begin
      vec = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    end else if (c < 3) begin
      vec = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    end else if (t / WORD_CY >= len) begin
      k   = len;
      vec = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    end else begin
      k = t / WORD_CY;
      r = t % WORD_CY;
      if (r < SLOT * W) begin
        ph  = r % SLOT;
        vec = {ph == 1, ph == 3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      end else if (r == SLOT * W) begin
        vec = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      end else begin
        vec = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      end
    end
    a = addr + AW'(k);
  endfunction

  task automatic run_transfer(input logic [AW-1:0] addr, input int len, input int abort_at,
                              input string tag);
    logic [6:0]    exp_vec, got_vec;
    logic [AW-1:0] exp_a;
    int k, r, last_c;
    int writes, sel_cyc, s1, s2, first_done;
    writes = 0; sel_cyc = 0; s1 = 0; s2 = 0; first_done = -1;
    BGN = 1'b0; ADDR_BGN = addr; DATA_LEN = 8'(len); SPI_SI = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    BGN = 1'b1;
    last_c = 3 + WORD_CY * len + 4;
    for (int c = 0; c <= last_c; c++) begin
      model_cycle(c, addr, len, exp_vec, exp_a, k, r);
      if (c > 0) begin
        @(posedge CLK);
        #1;
        // Real bit only in the slot's last phase; everything else is noise.
        if (r >= 0 && r < SLOT * W && (r % SLOT) == SLOT - 1) SPI_SI = words[k][r / SLOT];
        else SPI_SI = 1'($urandom_range(0, 1));
        if (c == abort_at) begin
          #1 BGN = 1'b0;
          #1;
          vectors++;
          if ({SCLK1, SCLK2, SEL, CEN, D_WE, spi_MUX, spi_is_done} !== 7'b0001100) begin
            miscompares++;
            $display("FAIL %s abort_outputs got=%b exp=%b", tag,
                     {SCLK1, SCLK2, SEL, CEN, D_WE, spi_MUX, spi_is_done}, 7'b0001100);
          end
          vectors++;
          if (A !== addr || PO !== '0) begin
            miscompares++;
            $display("FAIL %s abort_addr_data got A=%h PO=%h exp A=%h PO=00", tag, A, PO, addr);
          end
          vectors++;
          if (writes !== 0) begin
            miscompares++;
            $display("FAIL %s abort_no_write got=%0d exp=0", tag, writes);
          end
          return;
        end
        @(negedge CLK);
      end else begin
        #1;
      end
      got_vec = {SCLK1, SCLK2, SEL, CEN, D_WE, spi_MUX, spi_is_done};
      vectors++;
      if (got_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL %s ctrl c=%0d got=%b exp=%b", tag, c, got_vec, exp_vec);
      end
      vectors++;
      if (A !== exp_a) begin
        miscompares++;
        $display("FAIL %s addr c=%0d got=%h exp=%h", tag, c, A, exp_a);
      end
      if (r == SLOT * W) begin
        vectors++;
        if (PO !== exp_word(words[k])) begin
          miscompares++;
          $display("FAIL %s wdata word=%0d got=%h exp=%h", tag, k, PO, exp_word(words[k]));
        end
      end
      if (D_WE === 1'b0) writes++;
      if (SCLK1 === 1'b1) s1++;
      if (SCLK2 === 1'b1) s2++;
      if (SEL === 1'b1) sel_cyc++;
      if (spi_is_done === 1'b1 && first_done < 0) first_done = c;
    end
    vectors++;
    if (first_done != 3 + WORD_CY * len) begin
      miscompares++;
      $display("FAIL %s done_edge got=%0d exp=%0d", tag, first_done, 3 + WORD_CY * len);
    end
    vectors++;
    if (writes != len) begin
      miscompares++;
      $display("FAIL %s write_count got=%0d exp=%0d", tag, writes, len);
    end
    vectors++;
    if (s1 != W * len || s2 != W * len) begin
      miscompares++;
      $display("FAIL %s sclk_pulses got=%0d/%0d exp=%0d", tag, s1, s2, W * len);
    end
    vectors++;
    if (sel_cyc != 2) begin
      miscompares++;
      $display("FAIL %s sel_cycles got=%0d exp=2", tag, sel_cyc);
    end
  endtask

  task automatic test_reset();
    BGN = 1'b0; ADDR_BGN = 9'h123; DATA_LEN = 8'd5; SPI_SI = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if ({SCLK1, SCLK2, SEL, CEN, D_WE, spi_MUX, spi_is_done} !== 7'b0001100) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {SCLK1, SCLK2, SEL, CEN, D_WE, spi_MUX, spi_is_done}, 7'b0001100);
    end
    vectors++;
    if (A !== 9'h123 || PO !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_addr_data got A=%h PO=%h exp A=123 PO=00", A, PO);
    end
    ADDR_BGN = 9'h0AB;
    @(negedge CLK);
    vectors++;
    if (A !== 9'h0AB) begin
      miscompares++;
      $display("FAIL reset_addr_track got=%h exp=0ab", A);
    end
  endtask

  task automatic test_two_words();
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    run_transfer(9'h010, 2, -1, "two_words");
  endtask

  task automatic test_zero_len();
    run_transfer(9'h055, 0, -1, "zero_len");
  endtask

  task automatic test_addr_wrap();
    words[0] = W'($urandom);
    words[1] = W'($urandom);
    run_transfer(9'h1FF, 2, -1, "addr_wrap");
  endtask

  task automatic test_abort();
    words[0] = W'($urandom);
    run_transfer(9'h020, 1, 30, "abort");
    run_transfer(9'h020, 1, -1, "abort_restart");
  endtask

  task automatic test_bit_order();
    words[0] = 8'h01;
    run_transfer(9'h033, 1, -1, "bit_order");
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 8; i++) words[i] = W'($urandom);
      run_transfer(AW'($urandom), int'($urandom_range(1, 6)), -1, "random");
    end
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 256; i++) words[i] = W'($urandom);
    run_transfer(AW'($urandom), 255, -1, "max_len");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    BGN         = 1'b0;
    ADDR_BGN    = '0;
    DATA_LEN    = '0;
    SPI_SI      = 1'b0;
    test_reset();
    test_two_words();
    test_zero_len();
    test_addr_wrap();
    test_abort();
    test_bit_order();
    test_random();
    test_max_len();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
